controlador_ajuste: RTL

Time/date setting controller for the digital clock-calendar. It turns four debounced front-panel buttons into an edit-mode state machine that selects one field (hour, minute, day, month, year). It then routes single-cycle increment/decrement pulses, with hold-to-repeat, to that field's counter (the `aumenta`/`disminuye` inputs of the field counters). It also freezes timekeeping while editing and drives a blink enable for the selected display digits.

---
 rtl/controlador_ajuste.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/controlador_ajuste.sv
// controlador_ajuste: time/date setting controller for the clock-calendar.
// Turns four debounced front-panel buttons into an edit-mode state machine,
// issues one-cycle increment/decrement pulses (with hold-to-repeat) to the
// selected field counter, pauses timekeeping while editing and drives a
// blink enable for the selected digits.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   btn_modo/sig/arriba/abajo   debounced button levels
//   en_ajuste                   high in any edit state (time-base pause)
//   campo_sel[2:0]              0 none, 1 hour, 2 min, 3 day, 4 month, 5 year
//   aum_* / dis_*               one-cycle increment / decrement pulses
//   parpadeo                    blink enable for the selected field
module controlador_ajuste #(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned TIMEOUT       = 500_000_000,
    parameter int unsigned BLINK_HALF    = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_modo,
    input  logic       btn_sig,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    output logic       en_ajuste,
    output logic [2:0] campo_sel,
    output logic       aum_hora,
    output logic       aum_min,
    output logic       aum_dia,
    output logic       aum_mes,
    output logic       aum_ano,
    output logic       dis_hora,
    output logic       dis_min,
    output logic       dis_dia,
    output logic       dis_mes,
    output logic       dis_ano,
    output logic       parpadeo
);

    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        E_HORA = 3'd1,
        E_MIN  = 3'd2,
        E_DIA  = 3'd3,
        E_MES  = 3'd4,
        E_ANO  = 3'd5
    } state_t;

    state_t        state;
    state_t        next_field;
    logic [3:0]    btn_cur;      // {modo, sig, arriba, abajo}
    logic [3:0]    btn_prev;
    logic [3:0]    btn_edge;
    logic          en_q;
    logic          parp_q;
    logic [4:0]    aum_q;
    logic [4:0]    dis_q;
    logic [4:0]    field_oh;
    logic [TW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;
    logic [HW-1:0] hold_cnt;
    logic          rep_act;      // a press is being held and may repeat
    logic          rep_dir;      // 1 = arriba, 0 = abajo
    logic          rep_ph;       // 0 = waiting initial delay, 1 = periodic

    logic          modo_ev;
    logic          sig_ev;
    logic          all_low;
    logic          timeout_hit;

    logic          pulse_up_c;
    logic          pulse_dn_c;
    logic [HW-1:0] hold_nxt;
    logic          rep_act_nxt;
    logic          rep_dir_nxt;
    logic          rep_ph_nxt;

    assign btn_edge    = btn_cur & ~btn_prev;
    assign modo_ev     = btn_edge[3];
    assign sig_ev      = btn_edge[2];
    assign all_low     = (btn_cur == 4'b0000);
    assign timeout_hit = all_low && (idle_cnt == TW'(TIMEOUT - 1));

    // Field rotation for the next-field button
    always_comb begin
        next_field = E_HORA;
        case (state)
            E_HORA:  next_field = E_MIN;
            E_MIN:   next_field = E_DIA;
            E_DIA:   next_field = E_MES;
            E_MES:   next_field = E_ANO;
            default: next_field = E_HORA;
        endcase
    end

    // One-hot pulse routing, bit 0 = hour ... bit 4 = year
    always_comb begin
        field_oh = 5'b00000;
        case (state)
            E_HORA:  field_oh = 5'b00001;
            E_MIN:   field_oh = 5'b00010;
            E_DIA:   field_oh = 5'b00100;
            E_MES:   field_oh = 5'b01000;
            E_ANO:   field_oh = 5'b10000;
            default: field_oh = 5'b00000;
        endcase
    end

    // Press / hold-to-repeat decision; both levels high cancels everything
    always_comb begin
        pulse_up_c  = 1'b0;
        pulse_dn_c  = 1'b0;
        hold_nxt    = hold_cnt;
        rep_act_nxt = rep_act;
        rep_dir_nxt = rep_dir;
        rep_ph_nxt  = rep_ph;
        if (btn_cur[1] && btn_cur[0]) begin
            rep_act_nxt = 1'b0;
            rep_ph_nxt  = 1'b0;
            hold_nxt    = '0;
        end else if (btn_edge[1]) begin
            pulse_up_c  = 1'b1;
            rep_act_nxt = 1'b1;
            rep_dir_nxt = 1'b1;
            rep_ph_nxt  = 1'b0;
            hold_nxt    = HW'(1);
        end else if (btn_edge[0]) begin
            pulse_dn_c  = 1'b1;
            rep_act_nxt = 1'b1;
            rep_dir_nxt = 1'b0;
            rep_ph_nxt  = 1'b0;
            hold_nxt    = HW'(1);
        end else if (rep_act) begin
            if (!(rep_dir ? btn_cur[1] : btn_cur[0])) begin
                rep_act_nxt = 1'b0;
                rep_ph_nxt  = 1'b0;
                hold_nxt    = '0;
            end else if ((!rep_ph && hold_cnt == HW'(REPEAT_DELAY)) ||
                         ( rep_ph && hold_cnt == HW'(REPEAT_PERIOD))) begin
                pulse_up_c = rep_dir;
                pulse_dn_c = !rep_dir;
                rep_ph_nxt = 1'b1;
                hold_nxt   = HW'(1);
            end else begin
                hold_nxt = hold_cnt + 1'b1;
            end
        end
    end

    // Edit-mode state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            btn_cur   <= 4'hF;
            btn_prev  <= 4'hF;
            en_q      <= 1'b0;
            parp_q    <= 1'b0;
            aum_q     <= '0;
            dis_q     <= '0;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            hold_cnt  <= '0;
            rep_act   <= 1'b0;
            rep_dir   <= 1'b0;
            rep_ph    <= 1'b0;
        end else begin
            btn_cur  <= {btn_modo, btn_sig, btn_arriba, btn_abajo};
            btn_prev <= btn_cur;
            aum_q    <= '0;
            dis_q    <= '0;
            if (state == RUN) begin
                idle_cnt  <= '0;
                blink_cnt <= '0;
                hold_cnt  <= '0;
                rep_act   <= 1'b0;
                rep_ph    <= 1'b0;
                if (modo_ev) begin
                    state  <= E_HORA;
                    en_q   <= 1'b1;
                    parp_q <= 1'b1;
                end else begin
                    en_q   <= 1'b0;
                    parp_q <= 1'b0;
                end
            end else if (modo_ev || timeout_hit) begin
                state     <= RUN;
                en_q      <= 1'b0;
                parp_q    <= 1'b0;
                idle_cnt  <= '0;
                blink_cnt <= '0;
                hold_cnt  <= '0;
                rep_act   <= 1'b0;
                rep_ph    <= 1'b0;
            end else if (sig_ev) begin
                state     <= next_field;
                parp_q    <= 1'b1;
                idle_cnt  <= '0;
                blink_cnt <= '0;
                hold_cnt  <= '0;
                rep_act   <= 1'b0;
                rep_ph    <= 1'b0;
            end else begin
                // Idle counter saturates rather than wrapping
                if (!all_low) begin
                    idle_cnt <= '0;
                end else if (idle_cnt != TW'(TIMEOUT)) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                hold_cnt <= hold_nxt;
                rep_act  <= rep_act_nxt;
                rep_dir  <= rep_dir_nxt;
                rep_ph   <= rep_ph_nxt;
                if (pulse_up_c) begin
                    aum_q <= field_oh;
                end
                if (pulse_dn_c) begin
                    dis_q <= field_oh;
                end
                // Any pulse restarts the blink with digits visible
                if (pulse_up_c || pulse_dn_c) begin
                    parp_q    <= 1'b1;
                    blink_cnt <= '0;
                end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                    parp_q    <= ~parp_q;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign campo_sel = 3'(state);
    assign en_ajuste = en_q;
    assign parpadeo  = parp_q;
    assign aum_hora  = aum_q[0];
    assign aum_min   = aum_q[1];
    assign aum_dia   = aum_q[2];
    assign aum_mes   = aum_q[3];
    assign aum_ano   = aum_q[4];
    assign dis_hora  = dis_q[0];
    assign dis_min   = dis_q[1];
    assign dis_dia   = dis_q[2];
    assign dis_mes   = dis_q[3];
    assign dis_ano   = dis_q[4];

endmodule
